// File: rtl/array_pkg.sv
// Shared definitions for the array streaming data path.
//   state_t : reader FSM states
//   idx_w   : index width for a dimension of n entries (clog2, minimum 1 bit)
package array_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/array_index_counter.sv
// Two-level row/col index counter, row-major order.
// Ports:
//   clk, rst : clock, async active-high reset
//   clr      : force indices to [0][0]
//   inc      : advance to the next element
//   row, col : current indices
//   last     : indices point at [ROWS-1][COLS-1]
//   wrap     : advancing from the last element back to [0][0] this cycle
module array_index_counter
  import array_pkg::*;
#(
  parameter  int ROWS = 2,
  parameter  int COLS = 2,
  localparam int RW   = idx_w(ROWS),
  localparam int CW   = idx_w(COLS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic          last,
  output logic          wrap
);

  logic col_end;

  // With a single column/row the compare is always true, so that index never moves.
  assign col_end = (col == CW'(COLS - 1));
  assign last    = col_end && (row == RW'(ROWS - 1));
  assign wrap    = inc && last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row <= '0;
      col <= '0;
    end else if (clr || wrap) begin
      row <= '0;
      col <= '0;
    end else if (inc) begin
      if (col_end) begin
        col <= '0;
        row <= row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

endmodule

// File: rtl/array_stream_reader.sv
// Captures a ROWS x COLS array of WIDTH-bit words in one cycle and streams the
// elements out row-major on a valid/ready interface.
// Ports:
//   i_clk, i_rst   : clock, async active-high reset
//   i_load         : capture request (honoured only while idle)
//   i_array        : unpacked [ROWS][COLS] array of WIDTH-bit words
//   o_busy         : array held, stream in progress
//   o_valid/i_ready: element handshake
//   o_data         : current element, o_row/o_col its indices
//   o_last         : current element is [ROWS-1][COLS-1]
//   o_done         : one-cycle pulse after the final transfer
module array_stream_reader
  import array_pkg::*;
#(
  parameter  int WIDTH = 10,
  parameter  int ROWS  = 2,
  parameter  int COLS  = 2,
  localparam int RW    = idx_w(ROWS),
  localparam int CW    = idx_w(COLS)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_array [ROWS][COLS],
  output logic             o_busy,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic [RW-1:0]    o_row,
  output logic [CW-1:0]    o_col,
  output logic             o_last,
  output logic             o_done
);

  typedef logic [WIDTH-1:0] elem_t;

  state_t  state;
  elem_t   store [ROWS][COLS];
  elem_t   sel;
  logic    done_q;
  logic    streaming;
  logic    xfer;
  logic    capture;
  logic    idx_last;
  logic    idx_wrap;

  assign streaming = (state == STREAM);
  assign xfer      = streaming && i_ready;
  assign capture   = (state == IDLE) && i_load;

  array_index_counter #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_idx (
    .clk  (i_clk),
    .rst  (i_rst),
    .clr  (capture),
    .inc  (xfer),
    .row  (o_row),
    .col  (o_col),
    .last (idx_last),
    .wrap (idx_wrap)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state  <= IDLE;
      done_q <= 1'b0;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          store[r][c] <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (i_load) begin
            store <= i_array;
            state <= STREAM;
          end
        end
        STREAM: begin
          if (idx_wrap) begin
            state  <= IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Compare-based element mux: avoids index-width mismatches when a dimension is 1.
  always_comb begin
    sel = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (o_row == RW'(r) && o_col == CW'(c))
          sel = store[r][c];
  end

  assign o_busy  = streaming;
  assign o_valid = streaming;
  assign o_data  = streaming ? sel : '0;
  assign o_last  = streaming && idx_last;
  assign o_done  = done_q;

endmodule

// File: tb/tb_array_stream_reader.sv
module tb_array_stream_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic       ready = 1'b0;
  logic [9:0] arr [2][2];
  logic       busy, valid, last, done;
  logic [9:0] data;
  logic [0:0] row, col;

  logic       load1 = 1'b0;
  logic       ready1 = 1'b1;
  logic [9:0] arr1 [1][1];
  logic       busy1, valid1, last1, done1;
  logic [9:0] data1;
  logic [0:0] row1, col1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  array_stream_reader #(.WIDTH(10), .ROWS(2), .COLS(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_load(load), .i_array(arr),
    .o_busy(busy), .o_valid(valid), .i_ready(ready), .o_data(data),
    .o_row(row), .o_col(col), .o_last(last), .o_done(done)
  );

  array_stream_reader #(.WIDTH(10), .ROWS(1), .COLS(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_load(load1), .i_array(arr1),
    .o_busy(busy1), .o_valid(valid1), .i_ready(ready1), .o_data(data1),
    .o_row(row1), .o_col(col1), .o_last(last1), .o_done(done1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: a queue of the elements still to be delivered.
  typedef struct {
    logic [9:0] d;
    int         r;
    int         c;
  } ent_t;

  ent_t mq[$];
  logic m_done = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (mq.size() > 0) begin
        if (ready) begin
          if (mq[0].r == 1 && mq[0].c == 1) m_done = 1'b1;
          void'(mq.pop_front());
        end
      end else if (load) begin
        for (int r = 0; r < 2; r++)
          for (int c = 0; c < 2; c++)
            mq.push_back('{arr[r][c], r, c});
      end
    end
  end

  int log_q[$];
  int want[$];
  int done_cnt = 0;

  always @(negedge clk) begin
    logic       ev;
    logic [9:0] ed;
    int         er, ec;
    ev = (mq.size() > 0);
    ed = ev ? mq[0].d : 10'd0;
    er = ev ? mq[0].r : 0;
    ec = ev ? mq[0].c : 0;
    check("m_valid", valid, ev);
    check("m_busy",  busy,  ev);
    check("m_data",  data,  ed);
    check("m_row",   row,   er);
    check("m_col",   col,   ec);
    check("m_last",  last,  ev && er == 1 && ec == 1);
    check("m_done",  done,  m_done);
    if (valid && ready) log_q.push_back(int'(data));
    if (done) done_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_arr(input int a, input int b, input int c, input int d);
    arr[0][0] = 10'(a);
    arr[0][1] = 10'(b);
    arr[1][0] = 10'(c);
    arr[1][1] = 10'(d);
  endtask

  task automatic check_log(input string name, input int dones);
    check({name, "_count"}, log_q.size(), want.size());
    for (int i = 0; i < want.size(); i++)
      if (i < log_q.size()) check({name, "_elem"}, log_q[i], want[i]);
    check({name, "_dones"}, done_cnt, dones);
    log_q.delete();
    want.delete();
    done_cnt = 0;
  endtask

  initial begin
    int pat [7] = '{1, 0, 0, 1, 0, 1, 1};
    set_arr(0, 0, 0, 0);
    arr1[0][0] = 10'd0;

    // 1: reset then idle
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("idle_valid", valid, 0);
    check("idle_data", data, 0);
    check_log("idle", 0);

    // 2: full-rate stream
    set_arr(1, 2, 3, 4);
    ready = 1'b1;
    load  = 1'b1;
    step();
    load = 1'b0;
    check("t2_e0", {data, 1'b0, row, col, last}, {10'd1, 1'b0, 1'b0, 1'b0, 1'b0});
    step();
    check("t2_e1", {data, 1'b0, row, col, last}, {10'd2, 1'b0, 1'b0, 1'b1, 1'b0});
    step();
    check("t2_e2", {data, 1'b0, row, col, last}, {10'd3, 1'b0, 1'b1, 1'b0, 1'b0});
    step();
    check("t2_e3", {data, 1'b0, row, col, last}, {10'd4, 1'b0, 1'b1, 1'b1, 1'b1});
    step();
    check("t2_done", {done, valid}, 2'b10);
    step();
    check("t2_after", {done, valid}, 2'b00);
    want = '{1, 2, 3, 4};
    check_log("t2", 1);

    // 3: back-pressure
    load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 7; i++) begin
      ready = pat[i][0];
      step();
    end
    ready = 1'b1;
    step(); step();
    check("t3_idle", valid, 0);
    want = '{1, 2, 3, 4};
    check_log("t3", 1);

    // 4: load ignored mid-stream, reload in the done cycle
    load = 1'b1;
    step();
    set_arr(9, 9, 9, 9);
    for (int i = 0; i < 3; i++) step();
    load = 1'b0;
    set_arr(5, 6, 7, 8);
    step();
    check("t4_done_cycle", done, 1);
    load = 1'b1;
    step();
    load = 1'b0;
    check("t4_reload", data, 5);
    for (int i = 0; i < 6; i++) step();
    want = '{1, 2, 3, 4, 5, 6, 7, 8};
    check_log("t4", 2);

    // 5: reset mid-stream
    set_arr(1, 2, 3, 4);
    load = 1'b1;
    step();
    load = 1'b0;
    step(); step();
    rst = 1'b1;
    #1;
    check("t5_rst_out", {valid, busy, data, row, col}, 14'd0);
    step();
    rst = 1'b0;
    step();
    set_arr(5, 6, 7, 8);
    load = 1'b1;
    step();
    load = 1'b0;
    check("t5_restart", {data, row, col}, {10'd5, 1'b0, 1'b0});
    for (int i = 0; i < 6; i++) step();
    want = '{1, 2, 5, 6, 7, 8};
    check_log("t5", 1);

    // 6: degenerate 1x1 instance
    arr1[0][0] = 10'h3FF;
    load1 = 1'b1;
    step();
    load1 = 1'b0;
    check("t6_elem", {valid1, data1, row1, col1, last1, done1}, {1'b1, 10'h3FF, 1'b0, 1'b0, 1'b1, 1'b0});
    step();
    check("t6_done", {valid1, last1, done1}, 3'b001);
    step();
    check("t6_after", {valid1, busy1, done1}, 3'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
